// File: rtl/arm_pkg.sv
// Shared constants and types for the instruction-fetch slice.
package arm_pkg;

    localparam int INS_W = 32;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/next_pc_gen.sv
// Next program-counter selection: redirect to an aligned target, sequential
// advance, or hold.
module next_pc_gen
    import arm_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_advance,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_target;

    assign w_target = i_br_target & ~32'h0000_0003;

    // Redirect wins over sequential advance; otherwise the PC holds.
    always_comb begin
        o_next_pc = i_pc;
        if (i_br_taken) begin
            o_next_pc = w_target;
        end else if (i_advance) begin
            o_next_pc = i_pc + PC_INC;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and hands words to decode through a registered valid/ready slot.
module fetch_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned INS_MEM_SIZE = 32,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [INS_W-1:0] imem_ins,
    output logic [INS_W-1:0] if_ins,
    output logic [31:0]      if_pc,
    output logic             if_valid,
    input  logic             id_ready,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_cnt
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [INS_W-1:0] r_if_ins;
    logic [31:0]      r_if_pc;
    logic             r_if_valid;
    logic             r_fault;
    logic [CNT_W-1:0] r_fetch_cnt;

    logic w_slot_free;
    logic w_consumed;
    logic w_range_err;
    logic w_redirect;
    logic w_fault_evt;
    logic w_fetch;

    assign w_slot_free = !r_if_valid || id_ready;
    assign w_consumed  = r_if_valid && id_ready;
    assign w_range_err = ({2'b00, r_pc[31:2]} >= 32'(INS_MEM_SIZE));

    // State register; leaves IDLE one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode with priority redirect > range fault > halt > fetch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = halt ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
                if (br_taken) begin
                    w_state_nxt = ST_RUN;
                end else if (w_range_err && w_slot_free) begin
                    w_state_nxt = ST_FAULT;
                end else if (halt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!br_taken && !halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (br_taken) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-cycle action strobes derived from the current state.
    always_comb begin
        w_redirect  = 1'b0;
        w_fault_evt = 1'b0;
        w_fetch     = 1'b0;
        if (r_state != ST_IDLE && br_taken) begin
            w_redirect = 1'b1;
        end else if (r_state == ST_RUN && w_slot_free) begin
            if (w_range_err) begin
                w_fault_evt = 1'b1;
            end else if (!halt) begin
                w_fetch = 1'b1;
            end
        end
    end

    next_pc_gen u_next_pc_gen (
        .i_pc        (r_pc),
        .i_br_taken  (w_redirect),
        .i_br_target (br_target),
        .i_advance   (w_fetch),
        .o_next_pc   (w_pc_nxt)
    );

    // PC, IF/ID output slot, sticky fault flag and fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_if_ins    <= '0;
            r_if_pc     <= '0;
            r_if_valid  <= 1'b0;
            r_fault     <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_redirect) begin
                r_if_valid <= 1'b0;
                r_fault    <= 1'b0;
            end else if (w_fetch) begin
                r_if_ins    <= imem_ins;
                r_if_pc     <= r_pc;
                r_if_valid  <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end else begin
                if (w_consumed) begin
                    r_if_valid <= 1'b0;
                end
                if (w_fault_evt) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign if_ins    = r_if_ins;
    assign if_pc     = r_if_pc;
    assign if_valid  = r_if_valid;
    assign fault     = r_fault;
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of expected handoffs plus
// per-scenario cycle checks.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_ins;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        id_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        halt;
    logic        fault;
    logic [15:0] fetch_cnt;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sbq[$];

    logic [31:0] mem [0:31];
    logic [31:0] widx;

    fetch_stage #(
        .RESET_PC     (32'h0000_0000),
        .INS_MEM_SIZE (32),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_addr (imem_addr),
        .imem_ins  (imem_ins),
        .if_ins    (if_ins),
        .if_pc     (if_pc),
        .if_valid  (if_valid),
        .id_ready  (id_ready),
        .br_taken  (br_taken),
        .br_target (br_target),
        .halt      (halt),
        .fault     (fault),
        .fetch_cnt (fetch_cnt)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory; out-of-range words read as a marker.
    assign widx     = imem_addr >> 2;
    assign imem_ins = (widx < 32'd32) ? mem[widx[4:0]] : 32'hDEAD_BEEF;

    function automatic logic [31:0] word_of(input int idx);
        return 32'hA000_0000 + 32'(idx);
    endfunction

    function automatic exp_t mk_exp(input int idx);
        exp_t e;
        e.pc  = 32'(idx * 4);
        e.ins = word_of(idx);
        return e;
    endfunction

    // Scoreboard: every decode handoff must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_valid && id_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_unexpected: handoff pc=%h ins=%h, none expected", if_pc, if_ins);
            end else begin
                e = sbq.pop_front();
                if (if_pc !== e.pc || if_ins !== e.ins) begin
                    failures++;
                    $display("[TB] FAIL sb_handoff: got pc=%h ins=%h, want pc=%h ins=%h", if_pc, if_ins, e.pc, e.ins);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (if_valid !== 1'b0 || fault !== 1'b0 || fetch_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_flags: valid=%b fault=%b cnt=%0d, want 0/0/0", if_valid, fault, fetch_cnt);
        end
        checks++;
        if (imem_addr !== 32'h0 || if_ins !== 32'h0 || if_pc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_regs: addr=%h ins=%h pc=%h, want zeros", imem_addr, if_ins, if_pc);
        end
        id_ready = 1'b1;
        rst_n    = 1'b1;
    endtask

    task automatic test_sequential();
        checks++;
        if (imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_addr: addr=%h valid=%b, want 0/0", imem_addr, if_valid);
        end
        for (int i = 0; i < 4; i++) sbq.push_back(mk_exp(i));
        step();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL idle_nofetch: valid=%b addr=%h, want 0/0", if_valid, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_ins !== word_of(i) || if_pc !== 32'(i * 4)) begin
                failures++;
                $display("[TB] FAIL seq_capture%0d: valid=%b ins=%h pc=%h, want 1/%h/%h", i, if_valid, if_ins, if_pc, word_of(i), 32'(i * 4));
            end
        end
        checks++;
        if (fetch_cnt !== 16'd4 || imem_addr !== 32'h10) begin
            failures++;
            $display("[TB] FAIL seq_count: cnt=%0d addr=%h, want 4/00000010", fetch_cnt, imem_addr);
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (if_valid !== 1'b1 || if_ins !== word_of(3) || if_pc !== 32'hC || imem_addr !== 32'h10 || fetch_cnt !== 16'd4) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: valid=%b ins=%h pc=%h addr=%h cnt=%0d", c, if_valid, if_ins, if_pc, imem_addr, fetch_cnt);
            end
        end
        id_ready = 1'b1;
        step();
        checks++;
        if (if_ins !== word_of(4) || if_pc !== 32'h10 || fetch_cnt !== 16'd5 || imem_addr !== 32'h14) begin
            failures++;
            $display("[TB] FAIL stall_release: ins=%h pc=%h cnt=%0d addr=%h, want %h/10/5/14", if_ins, if_pc, fetch_cnt, imem_addr, word_of(4));
        end
    endtask

    task automatic test_branch();
        id_ready  = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h0000_0013;
        step();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h10 || fetch_cnt !== 16'd5) begin
            failures++;
            $display("[TB] FAIL br_flush: valid=%b addr=%h cnt=%0d, want 0/10/5", if_valid, imem_addr, fetch_cnt);
        end
        br_taken = 1'b0;
        id_ready = 1'b1;
        sbq.push_back(mk_exp(4));
        step();
        checks++;
        if (if_valid !== 1'b1 || if_ins !== word_of(4) || if_pc !== 32'h10 || fetch_cnt !== 16'd6) begin
            failures++;
            $display("[TB] FAIL br_target_fetch: valid=%b ins=%h pc=%h cnt=%0d", if_valid, if_ins, if_pc, fetch_cnt);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (if_valid !== 1'b0 || imem_addr !== 32'h14 || fetch_cnt !== 16'd6) begin
                failures++;
                $display("[TB] FAIL halt_hold%0d: valid=%b addr=%h cnt=%0d, want 0/14/6", c, if_valid, imem_addr, fetch_cnt);
            end
        end
        halt = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h14) begin
            failures++;
            $display("[TB] FAIL halt_exit: valid=%b addr=%h, want 0/14", if_valid, imem_addr);
        end
        for (int i = 5; i < 32; i++) begin
            sbq.push_back(mk_exp(i));
            step();
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_ins !== word_of(i)) begin
                failures++;
                $display("[TB] FAIL resume%0d: valid=%b pc=%h ins=%h", i, if_valid, if_pc, if_ins);
            end
        end
        checks++;
        if (fetch_cnt !== 16'd33 || imem_addr !== 32'h80) begin
            failures++;
            $display("[TB] FAIL resume_count: cnt=%0d addr=%h, want 33/80", fetch_cnt, imem_addr);
        end
    endtask

    task automatic test_fault();
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (fault !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h80 || fetch_cnt !== 16'd33) begin
                failures++;
                $display("[TB] FAIL fault_hold%0d: fault=%b valid=%b addr=%h cnt=%0d", c, fault, if_valid, imem_addr, fetch_cnt);
            end
        end
        br_taken  = 1'b1;
        br_target = 32'h0;
        step();
        checks++;
        if (fault !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fault_clear: fault=%b addr=%h valid=%b, want 0/0/0", fault, imem_addr, if_valid);
        end
        br_taken = 1'b0;
        id_ready = 1'b0;
        step();
        checks++;
        if (if_valid !== 1'b1 || if_ins !== word_of(0) || if_pc !== 32'h0 || fetch_cnt !== 16'd34) begin
            failures++;
            $display("[TB] FAIL fault_resume: valid=%b ins=%h pc=%h cnt=%0d", if_valid, if_ins, if_pc, fetch_cnt);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || fault !== 1'b0 || fetch_cnt !== 16'd0 || imem_addr !== 32'h0 || if_ins !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: valid=%b fault=%b cnt=%0d addr=%h ins=%h", if_valid, fault, fetch_cnt, imem_addr, if_ins);
        end
        checks++;
        if (sbq.size() !== 0) begin
            failures++;
            $display("[TB] FAIL sb_leftover: %0d entries, want 0", sbq.size());
        end
    endtask

    // Scenario sequence.
    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        id_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        halt      = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = word_of(i);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt();
        test_fault();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
